// File: rtl/cond_exec_stage.sv
// cond_exec_stage: conditional-execution pipeline stage with a single-entry output register.
//
// Each instruction's condition field is checked against the architectural flags (flags_o).
// A passing instruction updates the flags selected by flag_write_i and keeps its write enables.
// A failing instruction is squashed: its enables are forced low and the flags stay unchanged.
// The instruction still flows downstream as valid.
//
// Ports:
//   clk_i, rst_i            clock and synchronous active-high reset
//   valid_i / ready_o       upstream handshake (ready_o = ~valid_o | ready_i)
//   result_i, rd_i          ALU result and destination register, registered to result_o / rd_o
//   alu_flags_i             ALU flags {V,C,Z,N}
//   cond_i                  condition field (ARM-style encoding, 111x = always)
//   flag_write_i            bit1 writes N,Z; bit0 writes C,V
//   reg_write_i, mem_write_i, pc_src_i   unconditioned enables
//   valid_o / ready_i       downstream handshake
//   reg_write_o, mem_write_o, pc_src_o   condition-gated enables
//   flags_o                 architectural flag register {V,C,Z,N}
//   squash_cnt_o            saturating count of squashed instructions
//
// Configuration: define COND_STATS_EN to build the squash counter; otherwise squash_cnt_o is 0.

module cond_exec_stage #(
  parameter int unsigned N = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [N-1:0] result_i,
  input  logic [3:0]   alu_flags_i,
  input  logic [3:0]   cond_i,
  input  logic [1:0]   flag_write_i,
  input  logic         reg_write_i,
  input  logic         mem_write_i,
  input  logic         pc_src_i,
  input  logic [3:0]   rd_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [N-1:0] result_o,
  output logic [3:0]   rd_o,
  output logic         reg_write_o,
  output logic         mem_write_o,
  output logic         pc_src_o,
  output logic [3:0]   flags_o,
  output logic [15:0]  squash_cnt_o
);

  logic         valid_q;
  logic [N-1:0] result_q;
  logic [3:0]   rd_q;
  logic         reg_write_q, mem_write_q, pc_src_q;
  logic [3:0]   flags_q, flags_d;
  logic         passed;
  logic         accept, drain;

  // Flag aliases, {V,C,Z,N}
  logic flag_n, flag_z, flag_c, flag_v;
  assign flag_n = flags_q[0];
  assign flag_z = flags_q[1];
  assign flag_c = flags_q[2];
  assign flag_v = flags_q[3];

  assign ready_o = ~valid_q | ready_i;
  assign accept  = valid_i & ready_o;
  assign drain   = valid_q & ready_i;

  // Condition evaluated against the architectural flags, so an update from the previous
  // accepted instruction is already visible here.
  always_comb begin
    passed = 1'b0;
    unique case (cond_i)
      4'b0000: passed = flag_z;
      4'b0001: passed = ~flag_z;
      4'b0010: passed = flag_c;
      4'b0011: passed = ~flag_c;
      4'b0100: passed = flag_n;
      4'b0101: passed = ~flag_n;
      4'b0110: passed = flag_v;
      4'b0111: passed = ~flag_v;
      4'b1000: passed = flag_c & ~flag_z;
      4'b1001: passed = ~flag_c | flag_z;
      4'b1010: passed = (flag_n == flag_v);
      4'b1011: passed = (flag_n != flag_v);
      4'b1100: passed = ~flag_z & (flag_n == flag_v);
      4'b1101: passed = flag_z | (flag_n != flag_v);
      default: passed = 1'b1;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (accept && passed) begin
      if (flag_write_i[1]) flags_d[1:0] = alu_flags_i[1:0];
      if (flag_write_i[0]) flags_d[3:2] = alu_flags_i[3:2];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= 1'b0;
      result_q    <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
      pc_src_q    <= 1'b0;
      flags_q     <= '0;
    end else begin
      flags_q <= flags_d;
      if (accept) begin
        // Squashed instructions still occupy the slot, just with enables cleared.
        valid_q     <= 1'b1;
        result_q    <= result_i;
        rd_q        <= rd_i;
        reg_write_q <= reg_write_i & passed;
        mem_write_q <= mem_write_i & passed;
        pc_src_q    <= pc_src_i & passed;
      end else if (drain) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef COND_STATS_EN
  logic [15:0] squash_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      squash_cnt_q <= '0;
    end else if (accept && !passed && (squash_cnt_q != 16'hFFFF)) begin
      squash_cnt_q <= squash_cnt_q + 16'd1;
    end
  end

  assign squash_cnt_o = squash_cnt_q;
`else
  assign squash_cnt_o = '0;
`endif

  assign valid_o     = valid_q;
  assign result_o    = result_q;
  assign rd_o        = rd_q;
  assign reg_write_o = reg_write_q;
  assign mem_write_o = mem_write_q;
  assign pc_src_o    = pc_src_q;
  assign flags_o     = flags_q;

endmodule
